// File: rtl/pcie_ts_pkg.sv
// Shared types and address helpers for the PCIe TS read-request scheduler.
package pcie_ts_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ISSUE0,
        ST_ISSUE1,
        ST_GAP
    } sched_state_t;

    localparam int          LINE_BYTES  = 64;
    localparam logic [31:0] BANK_STRIDE = 32'h20000;

    function automatic logic [31:0] line_addr(input logic        bank,
                                              input logic [31:0] line);
        return (bank ? BANK_STRIDE : 32'h0) + line * 32'(LINE_BYTES);
    endfunction

endpackage

// File: rtl/pcie_credit_cnt.sv
// Saturating line-credit counter: +1 per committed line, -2 per issued burst.
module pcie_credit_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        case ({inc, dec})
            2'b10: begin
                if (count != '1)
                    count_nxt = count + WIDTH'(1);
            end
            2'b01: begin
                if (count >= WIDTH'(2))
                    count_nxt = count - WIDTH'(2);
                else
                    count_nxt = '0;
            end
            2'b11: begin
                if (count != '0)
                    count_nxt = count - WIDTH'(1);
            end
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else
            count <= count_nxt;
    end

endmodule

// File: rtl/pcie_ts_rd_sched.sv
// Ping-pong read-address scheduler for the TS read buffer.
// Optional counters: define PCIE_TS_RD_SCHED_STATS_EN.
module pcie_ts_rd_sched
    import pcie_ts_pkg::*;
#(
    parameter int BANK_LINES = 2048,
    parameter int CREDIT_W   = 16,
    parameter int BURST_GAP  = 2
) (
    input  logic                clk_pcie,
    input  logic                rst_pcie_n,
    input  logic                dma_write_start,
    input  logic                dma_write_end,
    input  logic                ts_line_valid,
    input  logic                dma_rdata_busy,
    output logic                dma_raddr_en,
    output logic [31:0]         dma_raddr,
    output logic                sched_active,
    output logic                sched_done,
    output logic [CREDIT_W-1:0] credit_cnt
`ifdef PCIE_TS_RD_SCHED_STATS_EN
    ,
    output logic [31:0]         stat_bursts,
    output logic [31:0]         stat_stalls
`endif
);

    localparam int LINE_W = $clog2(BANK_LINES);
    localparam int GAP_W  = (BURST_GAP > 1) ? $clog2(BURST_GAP) : 1;

    sched_state_t      state, state_nxt;
    logic              end_pend, end_pend_nxt;
    logic              restart_pend, restart_nxt;
    logic              ptr_bank, ptr_bank_nxt;
    logic [LINE_W-1:0] ptr_line, ptr_line_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
    logic              credit_ok;
    logic              issue_dec;

    assign credit_ok = credit_cnt >= CREDIT_W'(2);
    assign issue_dec = (state == ST_WAIT) && (state_nxt == ST_ISSUE0);

    pcie_credit_cnt #(
        .WIDTH (CREDIT_W)
    ) u_credit (
        .clk   (clk_pcie),
        .rst_n (rst_pcie_n),
        .inc   (ts_line_valid),
        .dec   (issue_dec),
        .count (credit_cnt)
    );

    always_comb begin
        state_nxt    = state;
        end_pend_nxt = end_pend;
        restart_nxt  = restart_pend;
        ptr_bank_nxt = ptr_bank;
        ptr_line_nxt = ptr_line;
        gap_cnt_nxt  = gap_cnt;
        unique case (state)
            ST_IDLE: begin
                ptr_bank_nxt = 1'b0;
                ptr_line_nxt = '0;
                restart_nxt  = 1'b0;
                end_pend_nxt = dma_write_start && dma_write_end;
                if (dma_write_start)
                    state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A start seen while waiting takes effect on this very issue.
                if (dma_write_start) begin
                    ptr_bank_nxt = 1'b0;
                    ptr_line_nxt = '0;
                    restart_nxt  = 1'b0;
                end
                if (end_pend)
                    state_nxt = ST_IDLE;
                else if (credit_ok && !dma_rdata_busy)
                    state_nxt = ST_ISSUE0;
            end
            ST_ISSUE0: begin
                state_nxt = ST_ISSUE1;
            end
            ST_ISSUE1: begin
                if (ptr_line == LINE_W'(BANK_LINES - 2)) begin
                    ptr_line_nxt = '0;
                    ptr_bank_nxt = ~ptr_bank;
                end else begin
                    ptr_line_nxt = ptr_line + LINE_W'(2);
                end
                gap_cnt_nxt = '0;
                state_nxt   = (BURST_GAP == 0) ? ST_WAIT : ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == GAP_W'(BURST_GAP - 1))
                    state_nxt = ST_WAIT;
                else
                    gap_cnt_nxt = gap_cnt + GAP_W'(1);
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (state != ST_IDLE && dma_write_end)
            end_pend_nxt = 1'b1;
        if (state inside {ST_ISSUE0, ST_ISSUE1, ST_GAP} && dma_write_start)
            restart_nxt = 1'b1;

        // Deferred restart lands once the in-flight burst is done.
        if (state_nxt == ST_WAIT && state inside {ST_ISSUE1, ST_GAP}
            && (restart_pend || dma_write_start)) begin
            ptr_bank_nxt = 1'b0;
            ptr_line_nxt = '0;
            restart_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk_pcie or negedge rst_pcie_n) begin
        if (!rst_pcie_n) begin
            state        <= ST_IDLE;
            end_pend     <= 1'b0;
            restart_pend <= 1'b0;
            ptr_bank     <= 1'b0;
            ptr_line     <= '0;
            gap_cnt      <= '0;
        end else begin
            state        <= state_nxt;
            end_pend     <= end_pend_nxt;
            restart_pend <= restart_nxt;
            ptr_bank     <= ptr_bank_nxt;
            ptr_line     <= ptr_line_nxt;
            gap_cnt      <= gap_cnt_nxt;
        end
    end

    always_ff @(posedge clk_pcie or negedge rst_pcie_n) begin
        if (!rst_pcie_n) begin
            dma_raddr_en <= 1'b0;
            dma_raddr    <= '0;
            sched_active <= 1'b0;
            sched_done   <= 1'b0;
        end else begin
            dma_raddr_en <= state_nxt inside {ST_ISSUE0, ST_ISSUE1};
            if (state_nxt == ST_ISSUE0)
                dma_raddr <= line_addr(ptr_bank_nxt, 32'(ptr_line_nxt));
            else if (state_nxt == ST_ISSUE1)
                dma_raddr <= line_addr(ptr_bank, 32'(ptr_line))
                             + 32'(LINE_BYTES);
            sched_active <= state_nxt != ST_IDLE;
            sched_done   <= (state == ST_WAIT) && end_pend;
        end
    end

`ifdef PCIE_TS_RD_SCHED_STATS_EN
    logic stall_now;

    assign stall_now = (state == ST_WAIT) && credit_ok && dma_rdata_busy;

    always_ff @(posedge clk_pcie or negedge rst_pcie_n) begin
        if (!rst_pcie_n) begin
            stat_bursts <= '0;
            stat_stalls <= '0;
        end else begin
            stat_bursts <= (dma_write_start ? 32'h0 : stat_bursts)
                           + 32'(issue_dec);
            stat_stalls <= (dma_write_start ? 32'h0 : stat_stalls)
                           + 32'(stall_now);
        end
    end
`endif

endmodule

// File: tb/tb_pcie_ts_rd_sched.sv
// Scoreboard bench for pcie_ts_rd_sched (small banks to reach the wrap).
module tb_pcie_ts_rd_sched;

    localparam int BL = 4;
    localparam int CW = 16;
    localparam int BG = 2;

    logic          clk_pcie = 1'b0;
    logic          rst_pcie_n = 1'b0;
    logic          dma_write_start = 1'b0;
    logic          dma_write_end = 1'b0;
    logic          ts_line_valid = 1'b0;
    logic          dma_rdata_busy = 1'b0;
    logic          dma_raddr_en;
    logic [31:0]   dma_raddr;
    logic          sched_active;
    logic          sched_done;
    logic [CW-1:0] credit_cnt;
`ifdef PCIE_TS_RD_SCHED_STATS_EN
    logic [31:0]   stat_bursts;
    logic [31:0]   stat_stalls;
`endif

    pcie_ts_rd_sched #(
        .BANK_LINES (BL),
        .CREDIT_W   (CW),
        .BURST_GAP  (BG)
    ) dut (
        .clk_pcie        (clk_pcie),
        .rst_pcie_n      (rst_pcie_n),
        .dma_write_start (dma_write_start),
        .dma_write_end   (dma_write_end),
        .ts_line_valid   (ts_line_valid),
        .dma_rdata_busy  (dma_rdata_busy),
        .dma_raddr_en    (dma_raddr_en),
        .dma_raddr       (dma_raddr),
        .sched_active    (sched_active),
        .sched_done      (sched_done),
        .credit_cnt      (credit_cnt)
`ifdef PCIE_TS_RD_SCHED_STATS_EN
        ,
        .stat_bursts     (stat_bursts),
        .stat_stalls     (stat_stalls)
`endif
    );

    always #5 clk_pcie = ~clk_pcie;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          strobes = 0;
    int          dones = 0;
    logic [31:0] sb[$];
    int          strobe_cyc[$];
    logic [31:0] exp_addr;

    initial forever begin
        @(posedge clk_pcie);
        cyc++;
    end

    initial forever begin
        @(negedge clk_pcie);
        if (sched_done)
            dones++;
        if (dma_raddr_en) begin
            strobes++;
            strobe_cyc.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL strobe_unexpected got=%h", dma_raddr);
            end else begin
                exp_addr = sb.pop_front();
                if (dma_raddr !== exp_addr) begin
                    failures++;
                    $display("FAIL strobe_addr got=%h exp=%h",
                             dma_raddr, exp_addr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_pcie);
        #1;
    endtask

    task automatic pulse_lines(input int n);
        repeat (n) begin
            ts_line_valid = 1'b1;
            tick();
            ts_line_valid = 1'b0;
        end
    endtask

    task automatic drain(input int max, input string name);
        for (int i = 0; i < max && sb.size() != 0; i++)
            tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain left=%0d exp=0", name, sb.size());
        end
    endtask

    task automatic end_session(input string name);
        int d0;
        d0 = dones;
        dma_write_end = 1'b1;
        tick();
        dma_write_end = 1'b0;
        for (int i = 0; i < 20 && sched_active; i++)
            tick();
        tick();
        checks++;
        if (sched_active !== 1'b0 || dones - d0 != 1) begin
            failures++;
            $display("FAIL %s_end active=%b dones=%0d exp 0/1",
                     name, sched_active, dones - d0);
        end
    endtask

    task automatic test_reset();
        rst_pcie_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({dma_raddr_en, sched_active, sched_done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000",
                     {dma_raddr_en, sched_active, sched_done});
        end
        checks++;
        if (dma_raddr !== 32'h0 || credit_cnt !== '0) begin
            failures++;
            $display("FAIL reset_vals addr=%h credit=%0d exp 0/0",
                     dma_raddr, credit_cnt);
        end
        rst_pcie_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        pulse_lines(4);
        checks++;
        if (credit_cnt !== CW'(4)) begin
            failures++;
            $display("FAIL basic_credit4 got=%0d exp=4", credit_cnt);
        end
        strobe_cyc.delete();
        sb.push_back(32'h0);
        sb.push_back(32'h40);
        sb.push_back(32'h80);
        sb.push_back(32'hC0);
        dma_write_start = 1'b1;
        tick();
        dma_write_start = 1'b0;
        checks++;
        if (sched_active !== 1'b1 || dma_raddr_en !== 1'b0) begin
            failures++;
            $display("FAIL basic_n1 active=%b en=%b exp 1/0",
                     sched_active, dma_raddr_en);
        end
        tick();
        checks++;
        if (dma_raddr_en !== 1'b1) begin
            failures++;
            $display("FAIL basic_n2 en=%b exp=1", dma_raddr_en);
        end
        drain(20, "basic");
        repeat (3) tick();
        checks++;
        if (credit_cnt !== '0) begin
            failures++;
            $display("FAIL basic_credit0 got=%0d exp=0", credit_cnt);
        end
        checks++;
        if (strobe_cyc.size() != 4 || strobe_cyc[1] - strobe_cyc[0] != 1
            || strobe_cyc[2] - strobe_cyc[0] != 3 + BG) begin
            failures++;
            $display("FAIL basic_spacing n=%0d exp 4 strobes period %0d",
                     strobe_cyc.size(), 3 + BG);
        end
        end_session("basic");
    endtask

    task automatic test_credit_gate();
        int  s0;
        logic found;
        pulse_lines(1);
        s0 = strobes;
        dma_write_start = 1'b1;
        tick();
        dma_write_start = 1'b0;
        repeat (8) tick();
        checks++;
        if (strobes != s0) begin
            failures++;
            $display("FAIL gate_idle strobes=%0d exp=0", strobes - s0);
        end
        sb.push_back(32'h0);
        sb.push_back(32'h40);
        ts_line_valid = 1'b1;
        tick();
        ts_line_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3 && !found; i++) begin
            tick();
            found = dma_raddr_en;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL gate_latency en=0 exp=1 within 3");
        end
        drain(10, "gate");
        end_session("gate");
    endtask

    task automatic test_busy();
        int s0;
        dma_rdata_busy = 1'b1;
        pulse_lines(8);
        s0 = strobes;
        dma_write_start = 1'b1;
        tick();
        dma_write_start = 1'b0;
        repeat (10) tick();
        checks++;
        if (strobes != s0) begin
            failures++;
            $display("FAIL busy_hold strobes=%0d exp=0", strobes - s0);
        end
`ifdef PCIE_TS_RD_SCHED_STATS_EN
        checks++;
        if (stat_stalls !== 32'd10) begin
            failures++;
            $display("FAIL busy_stalls got=%0d exp=10", stat_stalls);
        end
`endif
        sb.push_back(32'h0);
        sb.push_back(32'h40);
        sb.push_back(32'h80);
        sb.push_back(32'hC0);
        sb.push_back(32'h20000);
        sb.push_back(32'h20040);
        sb.push_back(32'h20080);
        sb.push_back(32'h200C0);
        dma_rdata_busy = 1'b0;
        tick();
        checks++;
        if (dma_raddr_en !== 1'b1) begin
            failures++;
            $display("FAIL busy_release en=%b exp=1", dma_raddr_en);
        end
        drain(40, "busy");
        checks++;
        if (credit_cnt !== '0) begin
            failures++;
            $display("FAIL busy_credit got=%0d exp=0", credit_cnt);
        end
        end_session("busy");
    endtask

    task automatic test_bank_wrap();
        logic [31:0] seq [10];
        seq = '{32'h0, 32'h40, 32'h80, 32'hC0, 32'h20000,
                32'h20040, 32'h20080, 32'h200C0, 32'h0, 32'h40};
        pulse_lines(10);
        foreach (seq[i])
            sb.push_back(seq[i]);
        dma_write_start = 1'b1;
        tick();
        dma_write_start = 1'b0;
        drain(60, "wrap");
        checks++;
        if (credit_cnt !== '0) begin
            failures++;
            $display("FAIL wrap_credit got=%0d exp=0", credit_cnt);
        end
`ifdef PCIE_TS_RD_SCHED_STATS_EN
        checks++;
        if (stat_bursts !== 32'd5) begin
            failures++;
            $display("FAIL wrap_bursts got=%0d exp=5", stat_bursts);
        end
`endif
        end_session("wrap");
    endtask

    task automatic test_end_in_issue0();
        int d0;
        pulse_lines(4);
        d0 = dones;
        sb.push_back(32'h0);
        sb.push_back(32'h40);
        dma_write_start = 1'b1;
        tick();
        dma_write_start = 1'b0;
        tick();
        checks++;
        if (dma_raddr_en !== 1'b1 || dma_raddr !== 32'h0) begin
            failures++;
            $display("FAIL endi_issue0 en=%b addr=%h exp 1/0",
                     dma_raddr_en, dma_raddr);
        end
        dma_write_end = 1'b1;
        tick();
        dma_write_end = 1'b0;
        checks++;
        if (dma_raddr_en !== 1'b1 || dma_raddr !== 32'h40) begin
            failures++;
            $display("FAIL endi_issue1 en=%b addr=%h exp 1/40",
                     dma_raddr_en, dma_raddr);
        end
        for (int i = 0; i < 20 && sched_active; i++)
            tick();
        repeat (3) tick();
        checks++;
        if (dones - d0 != 1 || sched_active !== 1'b0) begin
            failures++;
            $display("FAIL endi_done dones=%0d active=%b exp 1/0",
                     dones - d0, sched_active);
        end
        checks++;
        if (credit_cnt !== CW'(2)) begin
            failures++;
            $display("FAIL endi_credit got=%0d exp=2", credit_cnt);
        end
    endtask

    task automatic test_start_end_same();
        int d0;
        int s0;
        d0 = dones;
        s0 = strobes;
        dma_write_start = 1'b1;
        dma_write_end = 1'b1;
        tick();
        dma_write_start = 1'b0;
        dma_write_end = 1'b0;
        repeat (6) tick();
        checks++;
        if (dones - d0 != 1 || strobes != s0 || sched_active !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle dones=%0d strobes=%0d active=%b exp 1/0/0",
                     dones - d0, strobes - s0, sched_active);
        end
        checks++;
        if (credit_cnt !== CW'(2)) begin
            failures++;
            $display("FAIL same_credit got=%0d exp=2", credit_cnt);
        end
    endtask

    task automatic test_reset_mid_burst();
        sb.push_back(32'h0);
        sb.push_back(32'h40);
        dma_write_start = 1'b1;
        tick();
        dma_write_start = 1'b0;
        tick();
        tick();
        #5;
        checks++;
        if (dma_raddr_en !== 1'b1) begin
            failures++;
            $display("FAIL rstm_pre en=%b exp=1", dma_raddr_en);
        end
        rst_pcie_n = 1'b0;
        #1;
        checks++;
        if ({dma_raddr_en, sched_active, sched_done} !== 3'b000
            || dma_raddr !== 32'h0 || credit_cnt !== '0) begin
            failures++;
            $display("FAIL rstm_async en=%b act=%b done=%b addr=%h cr=%0d exp all 0",
                     dma_raddr_en, sched_active, sched_done,
                     dma_raddr, credit_cnt);
        end
        tick();
        rst_pcie_n = 1'b1;
        tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL rstm_sb left=%0d exp=0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_credit_gate();
        test_busy();
        test_bank_wrap();
        test_end_in_issue0();
        test_start_end_same();
        test_reset_mid_burst();
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
